// File: rtl/fc_pkg.sv
// Shared constants and state encoding for the FC layer sequencer.
package fc_pkg;

    localparam int DEF_BITWIDTH = 16;
    localparam int DEF_N_IN     = 10;
    localparam int DEF_N_OUT    = 10;
    localparam int DEF_SHIFT    = 8;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        WRITE,
        DONE
    } fc_state_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fc_mac_unit.sv
// Single signed multiply-accumulate shared across all output neurons.
module fc_mac_unit #(
    parameter int BITWIDTH = 16,
    parameter int ACC_W    = 2*BITWIDTH+4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       en,
    input  logic signed [BITWIDTH-1:0] a,
    input  logic signed [BITWIDTH-1:0] b,
    output logic signed [ACC_W-1:0]    acc
);

    logic signed [2*BITWIDTH-1:0] prod;

    assign prod = a * b;

    // Clear has priority so a new row never inherits the previous sum.
    always_ff @(posedge clk) begin
        if (rst || clr)
            acc <= '0;
        else if (en)
            acc <= acc + {{(ACC_W-2*BITWIDTH){prod[2*BITWIDTH-1]}}, prod};
    end

endmodule

// File: rtl/fc_layer_sequencer.sv
// Time-multiplexed FC output layer: one MAC walks the weight memory row by row,
// writing one scaled result per output neuron.
module fc_layer_sequencer
    import fc_pkg::*;
#(
    parameter int BITWIDTH = DEF_BITWIDTH,
    parameter int N_IN     = DEF_N_IN,
    parameter int N_OUT    = DEF_N_OUT,
    parameter int SHIFT    = DEF_SHIFT,
    parameter int ACC_W    = 2*BITWIDTH+4,
    parameter int WADDR_W  = $clog2(N_IN*N_OUT)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [N_IN-1:0][BITWIDTH-1:0]   feature_in,
    output logic                            w_rd_en,
    output logic [WADDR_W-1:0]              w_addr,
    input  logic signed [BITWIDTH-1:0]      w_data,
    output logic                            busy,
    output logic                            done,
    output logic [N_OUT-1:0][BITWIDTH-1:0]  out_vec
);

    localparam int IW = cnt_w(N_IN);
    localparam int JW = cnt_w(N_OUT);

    fc_state_t                     state, state_nx;
    logic [IW-1:0]                 i_q, i_d;
    logic [JW-1:0]                 j_q;
    logic [WADDR_W-1:0]            addr_q;
    logic                          rd_d;
    logic                          acc_clr;
    logic                          last_i, last_j;
    logic [N_IN-1:0][BITWIDTH-1:0] feat_q;
    logic signed [ACC_W-1:0]       acc;

    assign last_i = (i_q == IW'(N_IN-1));
    assign last_j = (j_q == JW'(N_OUT-1));
    // Rows are laid out contiguously, so j*N_IN+i is just a running count.
    assign w_addr = w_rd_en ? addr_q : '0;

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next state and per-state control strobes.
    always_comb begin
        state_nx = state;
        w_rd_en  = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        acc_clr  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = RUN;
                    acc_clr  = 1'b1;
                end
            end
            RUN: begin
                w_rd_en = 1'b1;
                busy    = 1'b1;
                if (last_i)
                    state_nx = DRAIN;
            end
            DRAIN: begin
                busy     = 1'b1;
                state_nx = WRITE;
            end
            WRITE: begin
                busy     = 1'b1;
                acc_clr  = 1'b1;
                state_nx = last_j ? DONE : RUN;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Counters, feature latch and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_q     <= '0;
            i_d     <= '0;
            j_q     <= '0;
            addr_q  <= '0;
            rd_d    <= 1'b0;
            feat_q  <= '0;
            out_vec <= '0;
        end else begin
            // Weight data returns one cycle after the read, so the feature
            // index travels alongside it.
            rd_d <= w_rd_en;
            i_d  <= i_q;
            case (state)
                IDLE: begin
                    if (start) begin
                        feat_q <= feature_in;
                        i_q    <= '0;
                        j_q    <= '0;
                        addr_q <= '0;
                    end
                end
                RUN: begin
                    i_q    <= last_i ? '0 : i_q + 1'b1;
                    addr_q <= addr_q + 1'b1;
                end
                WRITE: begin
                    // Bits [SHIFT +: BITWIDTH] are exactly (acc >>> SHIFT) truncated.
                    out_vec[j_q] <= acc[SHIFT +: BITWIDTH];
                    i_q          <= '0;
                    j_q          <= last_j ? '0 : j_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    fc_mac_unit #(
        .BITWIDTH (BITWIDTH),
        .ACC_W    (ACC_W)
    ) u_mac (
        .clk (clk),
        .rst (rst),
        .clr (acc_clr),
        .en  (rd_d),
        .a   ($signed(feat_q[i_d])),
        .b   (w_data),
        .acc (acc)
    );

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Scoreboard bench for fc_layer_sequencer with a 1-cycle-latency weight memory.
module tb_fc_layer_sequencer;

    localparam int BW   = 16;
    localparam int NI   = 10;
    localparam int NO   = 10;
    localparam int SH   = 8;
    localparam int WA   = $clog2(NI*NO);
    localparam int ROW  = NI + 2;
    localparam int LAST = NO * ROW;

    typedef logic [NI-1:0][BW-1:0] fvec_t;
    typedef logic [NO-1:0][BW-1:0] ovec_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    fvec_t                feature_in = '0;
    logic                 w_rd_en;
    logic [WA-1:0]        w_addr;
    logic signed [BW-1:0] w_data = '0;
    logic                 busy, done;
    ovec_t                out_vec;

    logic signed [BW-1:0] wmem [NI*NO];

    int    n_tests = 0, n_fail = 0;
    int    cyc = 0, c0 = 0;
    bit    active = 1'b0, aborted = 1'b0;
    int    last_busy = LAST;
    int    exp_addr = 0, rd_cnt = 0;
    ovec_t sb[$];

    fc_layer_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .feature_in (feature_in),
        .w_rd_en    (w_rd_en),
        .w_addr     (w_addr),
        .w_data     (w_data),
        .busy       (busy),
        .done       (done),
        .out_vec    (out_vec)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Weight memory: data one cycle after the strobe, junk otherwise.
    always @(posedge clk) w_data <= w_rd_en ? wmem[w_addr] : BW'($urandom);

    task automatic chk(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic ovec_t model(input fvec_t f);
        ovec_t  r;
        longint acc;
        for (int j = 0; j < NO; j++) begin
            acc = 0;
            for (int i = 0; i < NI; i++)
                acc += longint'($signed(f[i])) * longint'(wmem[j*NI+i]);
            r[j] = BW'(acc >>> SH);
        end
        return r;
    endfunction

    // Cycle-accurate monitor: timing of busy/done/read strobe, address order, results.
    always @(negedge clk) begin
        int    rel;
        bit    eb, er, ed;
        ovec_t e;
        rel = cyc - c0;
        if (active && rel == 0) begin
            exp_addr = 0;
            rd_cnt   = 0;
        end
        eb = active && rel >= 1 && rel <= last_busy;
        er = eb && (((rel - 1) % ROW) < NI);
        ed = active && !aborted && rel == LAST + 1;
        if (cyc >= 2) begin
            chk("busy", busy, eb);
            chk("done", done, ed);
            chk("w_rd_en", w_rd_en, er);
        end
        if (w_rd_en) begin
            chk("w_addr", w_addr, exp_addr);
            exp_addr++;
            rd_cnt++;
        end
        if (done) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                e = sb.pop_front();
                for (int j = 0; j < NO; j++)
                    chk($sformatf("out_vec[%0d]", j), $signed(out_vec[j]), $signed(e[j]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input fvec_t f, input ovec_t e);
        feature_in = f;
        start      = 1'b1;
        c0         = cyc;
        active     = 1'b1;
        aborted    = 1'b0;
        last_busy  = LAST;
        sb.push_back(e);
    endtask

    task automatic wait_rel(input int n);
        while (cyc - c0 < n) tick();
    endtask

    task automatic finish_run();
        wait_rel(LAST + 2);
        chk("rd_cnt", rd_cnt, NI*NO);
        chk("sb_empty", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        fvec_t f, fb;
        ovec_t e;

        for (int k = 0; k < NI*NO; k++) wmem[k] = '0;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_en", w_rd_en, 0);
        chk("rst_w_addr", w_addr, 0);
        for (int j = 0; j < NO; j++) chk("rst_out_vec", out_vec[j], 0);
        rst = 1'b0;
        tick();

        // Identity-scaled weights: out[j] = j+1.
        for (int j = 0; j < NO; j++)
            for (int i = 0; i < NI; i++)
                wmem[j*NI+i] = (i == j) ? BW'(256) : BW'(0);
        for (int i = 0; i < NI; i++) f[i] = BW'(i + 1);
        for (int j = 0; j < NO; j++) e[j] = BW'(j + 1);
        launch(f, e);
        tick();
        start = 1'b0;
        finish_run();

        // Negative features: -3*512*10 >>> 8 = -60.
        for (int k = 0; k < NI*NO; k++) wmem[k] = BW'(512);
        for (int i = 0; i < NI; i++) f[i] = BW'(-3);
        for (int j = 0; j < NO; j++) e[j] = BW'(-60);
        launch(f, e);
        tick();
        start = 1'b0;
        wait_rel(ROW);
        chk("acc_neg", dut.u_mac.acc, -64'sd15360);
        finish_run();

        // Full scale: accumulator must hold 10*32767^2 without wrapping.
        for (int k = 0; k < NI*NO; k++) wmem[k] = BW'(32767);
        for (int i = 0; i < NI; i++) f[i] = BW'(32767);
        for (int j = 0; j < NO; j++) e[j] = BW'(-2560);
        launch(f, e);
        tick();
        start = 1'b0;
        wait_rel(ROW);
        chk("acc_full", dut.u_mac.acc, 64'sd10736762890);
        finish_run();

        // start held high, feature_in changed mid-run; back-to-back second run.
        for (int k = 0; k < NI*NO; k++) wmem[k] = BW'($urandom);
        for (int i = 0; i < NI; i++) begin
            f[i]  = BW'($urandom);
            fb[i] = BW'($urandom);
        end
        launch(f, model(f));
        wait_rel(5);
        feature_in = fb;
        wait_rel(LAST + 2);
        chk("rd_cnt_held", rd_cnt, NI*NO);
        chk("sb_empty_held", sb.size(), 0);
        launch(fb, model(fb));
        tick();
        start = 1'b0;
        finish_run();

        // Reset mid-run, then a fresh run.
        for (int i = 0; i < NI; i++) f[i] = BW'($urandom);
        launch(f, model(f));
        tick();
        start = 1'b0;
        wait_rel(40);
        rst       = 1'b1;
        aborted   = 1'b1;
        last_busy = 40;
        sb.delete();
        tick();
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        for (int j = 0; j < NO; j++) chk("abort_out_vec", out_vec[j], 0);
        wait_rel(LAST + 5);
        for (int k = 0; k < NI*NO; k++) wmem[k] = BW'($urandom);
        for (int i = 0; i < NI; i++) f[i] = BW'($urandom);
        launch(f, model(f));
        tick();
        start = 1'b0;
        finish_run();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
